// File: rtl/ccd_acq_sequencer.sv
// Acquisition sequencer for the TCD1209D driver, AD9945 AFE and ccd2axis packer.
// Define ACQ_FRAME_COUNT_EN to build the optional frame counter on frame_cnt.
module ccd_acq_sequencer #(
    parameter int                CNT_W      = 23,
    parameter int                GAIN_W     = 10,
    parameter int                ROW_W      = 11,
    parameter logic [CNT_W-1:0]  MIN_PERIOD = 23'd2000,
    parameter logic [15:0]       CFG_WAIT   = 16'd64
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              upd_req,
    output logic              upd_ack,
    input  logic [CNT_W-1:0]  period_in,
    input  logic [GAIN_W-1:0] gain_in,
    input  logic [ROW_W-1:0]  rows_in,
    input  logic              sh_in,
    output logic [CNT_W-1:0]  f_cnt,
    output logic [GAIN_W-1:0] VGA_Gain,
    output logic              cfg_en,
    output logic [ROW_W-1:0]  rows,
    output logic              drv_en,
    output logic              frame_start,
    output logic [ROW_W-1:0]  line_cnt,
    output logic              busy,
    output logic              err_period,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_CFG_WAIT, S_RUN, S_DRAIN} state_t;

    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    function automatic logic [ROW_W-1:0] clamp_rows(input logic [ROW_W-1:0] r);
        return (r == '0) ? ROW_W'(1) : r;
    endfunction

    state_t            state_q, state_d;
    logic              sh_prev_q, edge_q, edge_d;
    logic [CNT_W-1:0]  shd_period_q, shd_period_d;
    logic [GAIN_W-1:0] shd_gain_q, shd_gain_d;
    logic [ROW_W-1:0]  shd_rows_q, shd_rows_d;
    logic              pend_q, pend_d;
    logic              defer_q, defer_d;
    logic [CNT_W-1:0]  hold_period_q, hold_period_d;
    logic [GAIN_W-1:0] hold_gain_q, hold_gain_d;
    logic [ROW_W-1:0]  hold_rows_q, hold_rows_d;
    logic [CNT_W-1:0]  f_cnt_q, f_cnt_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [ROW_W-1:0]  rows_q, rows_d, rows_stg_q, rows_stg_d;
    logic [ROW_W-1:0]  line_q, line_d;
    logic              fs_q, fs_d;
    logic              drv_q, drv_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              first_q, first_d;
    logic              gain_done_q, gain_done_d;
    logic              gcfg_pend_q, gcfg_pend_d;
    logic              stop_pend_q, stop_pend_d;
    logic [15:0]       wait_q, wait_d;

    logic              in_line;
    logic              edge_act;
    logic              commit;
    logic              frame_b;
    logic              gain_chg;
    logic              ld_en;
    logic [CNT_W-1:0]  ld_period;
    logic [GAIN_W-1:0] ld_gain;
    logic [ROW_W-1:0]  ld_rows;

    assign in_line   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign edge_d    = sh_in && !sh_prev_q && in_line;
    assign edge_act  = edge_q && in_line;
    assign commit    = pend_q && ((state_q == S_IDLE) || ((state_q == S_RUN) && edge_q));
    assign frame_b   = edge_act && (first_q || (line_q == rows_q - ROW_W'(1)));
    assign gain_chg  = commit && (shd_gain_q != gain_q);
    // A request colliding with a commit is parked in the hold registers for one cycle.
    assign ld_en     = (upd_req || defer_q) && !commit;
    assign ld_period = upd_req ? period_in : hold_period_q;
    assign ld_gain   = upd_req ? gain_in   : hold_gain_q;
    assign ld_rows   = upd_req ? rows_in   : hold_rows_q;

    always_comb begin
        state_d       = state_q;
        shd_period_d  = shd_period_q;
        shd_gain_d    = shd_gain_q;
        shd_rows_d    = shd_rows_q;
        pend_d        = pend_q;
        defer_d       = upd_req && commit;
        hold_period_d = hold_period_q;
        hold_gain_d   = hold_gain_q;
        hold_rows_d   = hold_rows_q;
        f_cnt_d       = f_cnt_q;
        gain_d        = gain_q;
        rows_d        = rows_q;
        rows_stg_d    = rows_stg_q;
        line_d        = line_q;
        fs_d          = 1'b0;
        drv_d         = drv_q;
        ack_d         = 1'b0;
        err_d         = err_q;
        first_d       = first_q;
        gain_done_d   = gain_done_q;
        gcfg_pend_d   = gcfg_pend_q;
        stop_pend_d   = stop_pend_q;
        wait_d        = wait_q;
        cfg_en        = 1'b0;

        if (commit) begin
            pend_d     = 1'b0;
            f_cnt_d    = shd_period_q;
            gain_d     = shd_gain_q;
            rows_stg_d = shd_rows_q;
            if (state_q == S_IDLE) rows_d = shd_rows_q;
            if (gain_chg) gcfg_pend_d = 1'b1;
        end

        if (upd_req && commit) begin
            hold_period_d = period_in;
            hold_gain_d   = gain_in;
            hold_rows_d   = rows_in;
        end else if (ld_en) begin
            shd_period_d = clamp_period(ld_period);
            shd_gain_d   = ld_gain;
            shd_rows_d   = clamp_rows(ld_rows);
            err_d        = (ld_period < MIN_PERIOD);
            pend_d       = 1'b1;
            ack_d        = 1'b1;
        end

        // Row count only changes where a new frame begins.
        if (frame_b) begin
            line_d = '0;
            fs_d   = 1'b1;
            rows_d = commit ? shd_rows_q : rows_stg_q;
        end else if (edge_act) begin
            line_d = line_q + ROW_W'(1);
        end
        if (edge_act) first_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    first_d = 1'b1;
                    if (gcfg_pend_q || !gain_done_q || gain_chg) state_d = S_CFG;
                    else                                         state_d = S_RUN;
                end
            end
            S_CFG: begin
                cfg_en      = 1'b1;
                gcfg_pend_d = 1'b0;
                gain_done_d = 1'b1;
                wait_d      = 16'd1;
                if (stop) stop_pend_d = 1'b1;
                state_d     = S_CFG_WAIT;
            end
            S_CFG_WAIT: begin
                if (stop) stop_pend_d = 1'b1;
                // The cfg_en cycle counts toward the serial-write allowance.
                if (wait_q >= CFG_WAIT - 16'd1) begin
                    first_d = 1'b1;
                    state_d = (stop_pend_q || stop) ? S_IDLE : S_RUN;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_RUN: begin
                if (stop && frame_b) begin
                    state_d = S_IDLE;
                end else if (gain_chg) begin
                    stop_pend_d = stop;
                    state_d     = S_CFG;
                end else if (stop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (frame_b) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_IDLE:         drv_d = 1'b0;
            S_RUN, S_DRAIN: drv_d = 1'b1;
            default:        drv_d = drv_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            sh_prev_q    <= 1'b0;
            edge_q       <= 1'b0;
            shd_period_q <= '0;
            shd_gain_q   <= '0;
            shd_rows_q   <= '0;
            pend_q       <= 1'b0;
            defer_q      <= 1'b0;
            f_cnt_q      <= MIN_PERIOD;
            gain_q       <= '0;
            rows_q       <= ROW_W'(1);
            rows_stg_q   <= ROW_W'(1);
            line_q       <= '0;
            fs_q         <= 1'b0;
            drv_q        <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            first_q      <= 1'b0;
            gain_done_q  <= 1'b0;
            gcfg_pend_q  <= 1'b0;
            stop_pend_q  <= 1'b0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            sh_prev_q    <= sh_in;
            edge_q       <= edge_d;
            shd_period_q <= shd_period_d;
            shd_gain_q   <= shd_gain_d;
            shd_rows_q   <= shd_rows_d;
            pend_q       <= pend_d;
            defer_q      <= defer_d;
            f_cnt_q      <= f_cnt_d;
            gain_q       <= gain_d;
            rows_q       <= rows_d;
            rows_stg_q   <= rows_stg_d;
            line_q       <= line_d;
            fs_q         <= fs_d;
            drv_q        <= drv_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            first_q      <= first_d;
            gain_done_q  <= gain_done_d;
            gcfg_pend_q  <= gcfg_pend_d;
            stop_pend_q  <= stop_pend_d;
            wait_q       <= wait_d;
        end
    end

    // Parked request data is only read when defer_q is set, so it needs no reset.
    always_ff @(posedge sys_clk) begin
        hold_period_q <= hold_period_d;
        hold_gain_q   <= hold_gain_d;
        hold_rows_q   <= hold_rows_d;
    end

`ifdef ACQ_FRAME_COUNT_EN
    logic [15:0] fcnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fcnt_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            fcnt_q <= '0;
        end else if (frame_b) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign frame_cnt = fcnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

    assign upd_ack     = ack_q;
    assign f_cnt       = f_cnt_q;
    assign VGA_Gain    = gain_q;
    assign rows        = rows_q;
    assign drv_en      = drv_q;
    assign frame_start = fs_q;
    assign line_cnt    = line_q;
    assign busy        = (state_q != S_IDLE);
    assign err_period  = err_q;

endmodule

// File: doc/ccd_acq_sequencer.md
Name: ccd_acq_sequencer

Overview:
- Top-level acquisition controller for the linear CCD chain: TCD1209D timing driver, AD9945 AFE and ccd2axis packer.
- Owns the line-period register (f_cnt), VGA gain and row count, all on sys_clk.
- Shadows host updates and commits them only at safe points: idle, or a line boundary.
- Sequences AD9945 serial reconfiguration, gates the CCD driver, and counts lines/frames so stop requests end on a frame boundary.

Parameters:
CNT_W, 23, width of line-period count (f_cnt)
GAIN_W, 10, width of AD9945 VGA gain
ROW_W, 11, width of rows-per-frame
MIN_PERIOD, 23'd2000, smallest legal line period; smaller requests are clamped
CFG_WAIT, 16'd64, sys_clk cycles allowed for one AD9945 serial write after cfg_en

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  level-sampled start request, acted on in IDLE only
stop  in  1  1-cycle pulse; stop at the end of the current frame
upd_req  in  1  shadow update request
upd_ack  out  1  1-cycle pulse when the shadow is loaded
period_in  in  CNT_W  requested line period
gain_in  in  GAIN_W  requested VGA gain
rows_in  in  ROW_W  requested rows per frame (0 treated as 1)
sh_in  in  1  SH line marker from the CCD driver, synchronous to sys_clk
f_cnt  out  CNT_W  active line period to the driver
VGA_Gain  out  GAIN_W  active gain to AD9945_cfg
cfg_en  out  1  1-cycle pulse to start an AD9945 serial write
rows  out  ROW_W  active rows to ccd2axis
drv_en  out  1  driver/AFE run enable
frame_start  out  1  1-cycle pulse at the first line of each frame
line_cnt  out  ROW_W  line index within the frame
busy  out  1  high whenever state != IDLE
err_period  out  1  sticky; set when period_in < MIN_PERIOD was accepted
frame_cnt  out  16  frame counter (optional feature)

Behaviour:
- Reset values: f_cnt=MIN_PERIOD, VGA_Gain=0, rows=1; all other outputs 0; state IDLE; shadow cleared and marked not pending.
- Shadow load:
  - upd_req is accepted in any state unless a commit occurs in the same cycle.
  - On acceptance, upd_ack pulses the next cycle.
  - A later request overwrites an uncommitted shadow.
  - period_in < MIN_PERIOD is stored as MIN_PERIOD and sets err_period.
  - An accepted in-range period clears err_period.
- Commit points: IDLE (any cycle with a pending shadow), or in RUN the cycle after the sh_in rising edge.
  - Commit copies the shadow to f_cnt/VGA_Gain/rows.
  - rows changes take effect only at a frame boundary (line_cnt wrap); f_cnt changes take effect per line.
- Gain reconfiguration: if a committed gain differs from VGA_Gain, go to CFG.
- States:
  - IDLE: drv_en=0. On start=1 go to CFG if a gain write is pending or not yet done since reset, else to RUN.
  - CFG: cfg_en=1 for exactly one cycle, then go to CFG_WAIT. drv_en keeps its previous value.
  - CFG_WAIT: count CFG_WAIT cycles, then go to RUN. If entered from IDLE via stop, return to IDLE instead.
  - RUN: drv_en=1.
    - Detect the sh_in rising edge using a registered previous value.
    - Each edge increments line_cnt; when line_cnt==rows-1 it wraps to 0 and frame_start pulses on the same cycle as the wrap.
    - The first edge after entering RUN gives line_cnt=0 and frame_start=1.
  - DRAIN (stop seen in RUN): keep running until the next wrap, then drv_en=0 and go to IDLE.
  - A stop in CFG/CFG_WAIT completes the wait, then goes to IDLE.
- Boundary cases:
  - Simultaneous stop and wrap: the frame ends immediately and the state goes to IDLE.
  - Simultaneous upd_req and commit: the commit uses the old shadow and upd_req is held off one cycle (upd_ack delayed by 1).
  - sh_in edges outside RUN/DRAIN are ignored.
  - Reset mid-operation returns all outputs to reset values asynchronously.
- Latency: sh_in rising edge to line_cnt update is 2 cycles (one cycle for edge registration, one for the update).

Optional Feature:
- Macro: ACQ_FRAME_COUNT_EN.
- Defined: frame_cnt increments (wrapping at 16'hFFFF to 0) on every frame_start pulse and is cleared on start from IDLE.
- Undefined: frame_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Reset, then upd_req with period=5000, gain=10'h120, rows=4, then start → upd_ack 1 cycle later; f_cnt=5000, rows=4; one cfg_en pulse; drv_en=1 exactly 64 cycles after cfg_en.
- RUN with 9 sh_in edges, rows=4 → frame_start at edges 1, 5, 9; line_cnt sequence 0,1,2,3,0,1,2,3,0.
- period_in=100 update → f_cnt=2000 and err_period=1; a later period_in=3000 update clears err_period.
- Gain change committed mid-RUN at an sh edge → state CFG, cfg_en pulse, VGA_Gain updated, RUN resumes after 64 cycles; same-gain update produces no cfg_en.
- stop at line_cnt=1 with rows=4 → drv_en falls on the wrap to 0, busy=0; stop coincident with wrap → IDLE the same cycle.
- Assert sys_rst_n low in CFG_WAIT → all outputs immediately at reset values; with ACQ_FRAME_COUNT_EN, frame_cnt=0 after reset and equals 3 after 3 frames.
